// File: rtl/mau_reliable_send_state_ctrl.sv
// Flowstate RAM owner for the reliable-send action unit: clear sweep, write-back/cfg arbitration, cfg reads.
// Optional statistics counters are built when RELI_STATE_STATS_EN is defined.
module mau_reliable_send_state_ctrl #(
    parameter int FLOWSTATE_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter logic [FLOWSTATE_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reliable_enable,
    input  logic                       wb_valid,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,
    input  logic [FLOWSTATE_WIDTH-1:0] wb_data,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       cfg_write,
    input  logic                       cfg_flush,
    input  logic [ADDR_WIDTH-1:0]      cfg_addr,
    input  logic [FLOWSTATE_WIDTH-1:0] cfg_wdata,
    output logic [FLOWSTATE_WIDTH-1:0] cfg_rdata,
    output logic                       cfg_rvalid,
    output logic                       dp_stall,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_waddr,
    output logic [FLOWSTATE_WIDTH-1:0] ram_wdata,
    output logic                       ram_re,
    output logic [ADDR_WIDTH-1:0]      ram_raddr,
    input  logic [FLOWSTATE_WIDTH-1:0] ram_rdata,
    output logic [31:0]                stat_wb_cnt,
    output logic [31:0]                stat_cfg_wr_cnt,
    output logic [31:0]                stat_drop_cnt
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH-1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CFG_RD, ST_FLUSH} state_t;

    state_t                     state_reg;
    logic [ADDR_WIDTH:0]        sweep_cnt_reg;
    logic                       enable_reg;
    logic                       flush_pend_reg;
    logic                       rd_phase_reg;
    logic                       fwd_hit_reg;
    logic [FLOWSTATE_WIDTH-1:0] fwd_data_reg;
    logic                       ram_we_reg;
    logic [ADDR_WIDTH-1:0]      ram_waddr_reg;
    logic [FLOWSTATE_WIDTH-1:0] ram_wdata_reg;
    logic                       ram_re_reg;
    logic [ADDR_WIDTH-1:0]      ram_raddr_reg;
    logic [FLOWSTATE_WIDTH-1:0] cfg_rdata_reg;
    logic                       cfg_rvalid_reg;
    logic                       dp_stall_reg;

    logic sweeping;
    logic flush_trig;
    logic cfg_accept;
    logic wr_hit;

    assign sweeping   = (state_reg == ST_INIT) || (state_reg == ST_FLUSH);
    assign flush_trig = cfg_flush | (enable_reg & ~reliable_enable);
    assign cfg_ready  = ~rst & (state_reg == ST_RUN) & ~wb_valid & ~flush_trig;
    assign cfg_accept = cfg_valid & cfg_ready;
    // A write visible on the RAM port this cycle to the address being read must win over ram_rdata.
    assign wr_hit     = ram_we_reg && (ram_waddr_reg == ram_raddr_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            sweep_cnt_reg  <= '0;
            enable_reg     <= 1'b0;
            flush_pend_reg <= 1'b0;
            rd_phase_reg   <= 1'b0;
            fwd_hit_reg    <= 1'b0;
            fwd_data_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_waddr_reg  <= '0;
            ram_wdata_reg  <= '0;
            ram_re_reg     <= 1'b0;
            ram_raddr_reg  <= '0;
            cfg_rdata_reg  <= '0;
            cfg_rvalid_reg <= 1'b0;
            dp_stall_reg   <= 1'b1;
        end else begin
            enable_reg     <= reliable_enable;
            ram_we_reg     <= 1'b0;
            ram_re_reg     <= 1'b0;
            cfg_rvalid_reg <= 1'b0;
            dp_stall_reg   <= sweeping;
            if (sweeping) begin
                ram_we_reg    <= 1'b1;
                ram_waddr_reg <= sweep_cnt_reg[ADDR_WIDTH-1:0];
                ram_wdata_reg <= INIT_VALUE;
                if (sweep_cnt_reg == LAST_IDX) begin
                    state_reg     <= ST_RUN;
                    sweep_cnt_reg <= '0;
                end else begin
                    sweep_cnt_reg <= sweep_cnt_reg + (ADDR_WIDTH+1)'(1);
                end
            end else begin
                if (wb_valid) begin
                    ram_we_reg    <= 1'b1;
                    ram_waddr_reg <= wb_addr;
                    ram_wdata_reg <= wb_data;
                end else if (cfg_accept && cfg_write) begin
                    ram_we_reg    <= 1'b1;
                    ram_waddr_reg <= cfg_addr;
                    ram_wdata_reg <= cfg_wdata;
                end
                case (state_reg)
                    ST_RUN: begin
                        if (flush_trig) begin
                            state_reg <= ST_FLUSH;
                        end else if (cfg_accept && !cfg_write) begin
                            ram_re_reg    <= 1'b1;
                            ram_raddr_reg <= cfg_addr;
                            rd_phase_reg  <= 1'b0;
                            fwd_hit_reg   <= 1'b0;
                            state_reg     <= ST_CFG_RD;
                        end
                    end
                    ST_CFG_RD: begin
                        if (!rd_phase_reg) begin
                            rd_phase_reg   <= 1'b1;
                            flush_pend_reg <= flush_pend_reg | flush_trig;
                            fwd_hit_reg    <= wr_hit;
                            fwd_data_reg   <= ram_wdata_reg;
                        end else begin
                            cfg_rvalid_reg <= 1'b1;
                            if (wr_hit)
                                cfg_rdata_reg <= ram_wdata_reg;
                            else if (fwd_hit_reg)
                                cfg_rdata_reg <= fwd_data_reg;
                            else
                                cfg_rdata_reg <= ram_rdata;
                            state_reg      <= (flush_pend_reg | flush_trig) ? ST_FLUSH : ST_RUN;
                            flush_pend_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ram_we     = ram_we_reg;
    assign ram_waddr  = ram_waddr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign ram_re     = ram_re_reg;
    assign ram_raddr  = ram_raddr_reg;
    assign cfg_rdata  = cfg_rdata_reg;
    assign cfg_rvalid = cfg_rvalid_reg;
    assign dp_stall   = dp_stall_reg;

`ifdef RELI_STATE_STATS_EN
    logic [31:0] stat_wb_cnt_reg;
    logic [31:0] stat_cfg_wr_cnt_reg;
    logic [31:0] stat_drop_cnt_reg;

    // Saturating counters; only rst clears them, a flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wb_cnt_reg     <= '0;
            stat_cfg_wr_cnt_reg <= '0;
            stat_drop_cnt_reg   <= '0;
        end else begin
            if (wb_valid && !sweeping && stat_wb_cnt_reg != 32'hFFFF_FFFF)
                stat_wb_cnt_reg <= stat_wb_cnt_reg + 32'd1;
            if (cfg_accept && cfg_write && stat_cfg_wr_cnt_reg != 32'hFFFF_FFFF)
                stat_cfg_wr_cnt_reg <= stat_cfg_wr_cnt_reg + 32'd1;
            if (wb_valid && sweeping && stat_drop_cnt_reg != 32'hFFFF_FFFF)
                stat_drop_cnt_reg <= stat_drop_cnt_reg + 32'd1;
        end
    end

    assign stat_wb_cnt     = stat_wb_cnt_reg;
    assign stat_cfg_wr_cnt = stat_cfg_wr_cnt_reg;
    assign stat_drop_cnt   = stat_drop_cnt_reg;
`else
    assign stat_wb_cnt     = 32'd0;
    assign stat_cfg_wr_cnt = 32'd0;
    assign stat_drop_cnt   = 32'd0;
`endif

endmodule
